// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : switch_pkg
// Purpose : Shared constants for the push-switch conditioning stage.
//           Debounce window defaults to 10 ms of the 25 MHz board clock.
// Revision: 1.0 - initial release
// ============================================================================
package switch_pkg;

  localparam int CLK_HZ                 = 25_000_000;
  localparam int DEBOUNCE_MS            = 10;
  localparam int DEBOUNCE_LIMIT_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int NUM_SW_DEFAULT         = 4;
  localparam int SYNC_STAGES_DEFAULT    = 2;

  // Width of a stability counter able to hold 0 .. limit-1.
  function automatic int cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module  : debounce_channel
// Purpose : One switch channel: synchroniser, stability counter, accepted
//           level register and registered press/release pulses.
// Revision: 1.0 - initial release
// ============================================================================
module debounce_channel
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release
);

  localparam int                CNT_W   = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic                   level_q,   level_d;
  logic                   press_q,   press_d;
  logic                   release_q, release_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Shift the raw pin through the synchroniser chain (bit 0 is first stage).
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_Switch};
    end
  end

  // Count consecutive cycles of disagreement; any agreement discards progress.
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync_bit == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d   = sync_bit;
      cnt_d     = '0;
      press_d   = sync_bit;
      release_d = ~sync_bit;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Register counter, level and pulses so pulses align with the level change.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_Switch  = level_q;
  assign o_Press   = press_q;
  assign o_Release = release_q;

endmodule
`default_nettype wire

// File: rtl/switch_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module  : switch_debounce_bank
// Purpose : NUM_SW independent debounce channels feeding the LED logic.
//           Define SWITCH_DEBOUNCE_TOGGLE_EN to add o_Toggle, a per-switch
//           on/off latch that flips the cycle after each accepted press.
// Revision: 1.0 - initial release
// ============================================================================
module switch_debounce_bank
  import switch_pkg::*;
#(
  parameter int NUM_SW         = NUM_SW_DEFAULT,
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Switch,
  output logic [NUM_SW-1:0] o_Press,
  output logic [NUM_SW-1:0] o_Release
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  ,
  output logic [NUM_SW-1:0] o_Toggle
`endif
);

  for (genvar k = 0; k < NUM_SW; k++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .i_Clk     (i_Clk),
      .i_Rst_n   (i_Rst_n),
      .i_Switch  (i_Switch[k]),
      .o_Switch  (o_Switch[k]),
      .o_Press   (o_Press[k]),
      .o_Release (o_Release[k])
    );
  end

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  logic [NUM_SW-1:0] toggle_q;

  // Flip each channel's latch one cycle after its press pulse.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ o_Press;
    end
  end

  assign o_Toggle = toggle_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_switch_debounce_bank
// Purpose : Self-checking bench for switch_debounce_bank with
//           DEBOUNCE_LIMIT=8, SYNC_STAGES=2 (pin-to-level latency 10 cycles).
// Revision: 1.0 - initial release
// ============================================================================
module tb_switch_debounce_bank;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic [3:0] o_sw, o_press, o_rel;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  logic [3:0] o_tog;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
  } ev_t;

  ev_t exp_q[$];

  switch_debounce_bank #(
    .NUM_SW         (4),
    .DEBOUNCE_LIMIT (8),
    .SYNC_STAGES    (2)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_Switch  (sw),
    .o_Switch  (o_sw),
    .o_Press   (o_press),
    .o_Release (o_rel)
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    ,
    .o_Toggle  (o_tog)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse the DUT emits is matched against the next expected event.
  always @(negedge clk) begin
    if ((o_press | o_rel) != 4'b0) begin
      checks++;
      if ((o_press & o_rel) != 4'b0) begin
        errors++;
        $display("FAIL pulse_exclusive: press=%b release=%b at cycle %0d", o_press, o_rel, cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: press=%b release=%b at cycle %0d, expected none", o_press, o_rel, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (cyc !== e.cyc || o_press !== e.press || o_rel !== e.rel) begin
          errors++;
          $display("FAIL pulse_event: got cycle=%0d press=%b release=%b, expected cycle=%0d press=%b release=%b",
                   cyc, o_press, o_rel, e.cyc, e.press, e.rel);
        end
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw    = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (o_sw !== 4'h0 || o_press !== 4'h0 || o_rel !== 4'h0) begin
        errors++;
        $display("FAIL reset_outputs: sw=%b press=%b release=%b, expected all 0", o_sw, o_press, o_rel);
      end
    end
    drive_edge();
    sw    = 4'h0;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_sw !== 4'h0) begin
      errors++;
      $display("FAIL reset_idle: sw=%b, expected 0000", o_sw);
    end
  endtask

  task automatic test_clean_press();
    int c;
    drive_edge();
    sw[0] = 1'b1;
    c = cyc;
    exp_q.push_back('{c + 10, 4'b0001, 4'b0000});
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_sw !== 4'b0000) begin
      errors++;
      $display("FAIL press_early: sw=%b at +9, expected 0000", o_sw);
    end
    @(negedge clk);
    checks++;
    if (o_sw !== 4'b0001 || o_press !== 4'b0001) begin
      errors++;
      $display("FAIL press_accept: sw=%b press=%b at +10, expected 0001/0001", o_sw, o_press);
    end
    @(negedge clk);
    checks++;
    if (o_sw !== 4'b0001 || o_press !== 4'b0000) begin
      errors++;
      $display("FAIL press_single: sw=%b press=%b at +11, expected 0001/0000", o_sw, o_press);
    end
  endtask

  task automatic test_bounce();
    int c;
    for (int i = 0; i < 40; i++) begin
      drive_edge();
      if (i % 3 == 0) sw[1] = ~sw[1];
      @(negedge clk);
      checks++;
      if (o_sw[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_hold: sw[1]=%b during bounce step %0d, expected 0", o_sw[1], i);
      end
    end
    drive_edge();
    sw[1] = 1'b1;
    c = cyc;
    exp_q.push_back('{c + 10, 4'b0010, 4'b0000});
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_sw !== 4'b0001) begin
      errors++;
      $display("FAIL bounce_early: sw=%b at +9, expected 0001", o_sw);
    end
    @(negedge clk);
    checks++;
    if (o_sw !== 4'b0011) begin
      errors++;
      $display("FAIL bounce_accept: sw=%b at +10, expected 0011", o_sw);
    end
  endtask

  task automatic test_release_glitch();
    int c;
    drive_edge();
    sw[2] = 1'b1;
    c = cyc;
    exp_q.push_back('{c + 10, 4'b0100, 4'b0000});
    repeat (12) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_sw !== 4'b0111) begin
      errors++;
      $display("FAIL ch2_press: sw=%b, expected 0111", o_sw);
    end
    drive_edge();
    sw[2] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    sw[2] = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_sw !== 4'b0111) begin
      errors++;
      $display("FAIL glitch_reject: sw=%b after 7-cycle glitch, expected 0111", o_sw);
    end
    drive_edge();
    sw[2] = 1'b0;
    c = cyc;
    exp_q.push_back('{c + 10, 4'b0000, 4'b0100});
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_sw !== 4'b0011 || o_rel !== 4'b0100) begin
      errors++;
      $display("FAIL release_accept: sw=%b release=%b, expected 0011/0100", o_sw, o_rel);
    end
    @(negedge clk);
    checks++;
    if (o_rel !== 4'b0000) begin
      errors++;
      $display("FAIL release_single: release=%b, expected 0000", o_rel);
    end
  endtask

  task automatic test_simultaneous_and_reset();
    int c;
    drive_edge();
    sw = 4'b0000;
    c = cyc;
    exp_q.push_back('{c + 10, 4'b0000, 4'b0011});
    repeat (12) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_sw !== 4'b0000) begin
      errors++;
      $display("FAIL all_released: sw=%b, expected 0000", o_sw);
    end
    drive_edge();
    sw = 4'hF;
    c = cyc;
    exp_q.push_back('{c + 10, 4'hF, 4'h0});
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_sw !== 4'hF || o_press !== 4'hF) begin
      errors++;
      $display("FAIL simultaneous_press: sw=%b press=%b, expected 1111/1111", o_sw, o_press);
    end
    // Release channels 0 and 1, then reset with their counters at 5.
    drive_edge();
    sw = 4'b1100;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_sw !== 4'h0 || o_press !== 4'h0 || o_rel !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: sw=%b press=%b release=%b, expected all 0", o_sw, o_press, o_rel);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    c = cyc;
    exp_q.push_back('{c + 10, 4'b1100, 4'b0000});
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_sw !== 4'b0000) begin
      errors++;
      $display("FAIL repress_early: sw=%b at +9, expected 0000", o_sw);
    end
    @(negedge clk);
    checks++;
    if (o_sw !== 4'b1100) begin
      errors++;
      $display("FAIL repress_accept: sw=%b at +10, expected 1100", o_sw);
    end
  endtask

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  task automatic test_toggle();
    int c;
    drive_edge();
    rst_n = 1'b0;
    sw    = 4'b0000;
    #1;
    checks++;
    if (o_tog !== 4'b0000) begin
      errors++;
      $display("FAIL toggle_reset: toggle=%b, expected 0000", o_tog);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 2; n++) begin
      drive_edge();
      sw[3] = 1'b1;
      c = cyc;
      exp_q.push_back('{c + 10, 4'b1000, 4'b0000});
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if (o_tog !== ((n == 0) ? 4'b0000 : 4'b1000)) begin
        errors++;
        $display("FAIL toggle_before: press %0d toggle=%b, expected %b", n, o_tog, (n == 0) ? 4'b0000 : 4'b1000);
      end
      @(negedge clk);
      checks++;
      if (o_tog !== ((n == 0) ? 4'b1000 : 4'b0000)) begin
        errors++;
        $display("FAIL toggle_after: press %0d toggle=%b, expected %b", n, o_tog, (n == 0) ? 4'b1000 : 4'b0000);
      end
      drive_edge();
      sw[3] = 1'b0;
      c = cyc;
      exp_q.push_back('{c + 10, 4'b0000, 4'b1000});
      repeat (12) @(posedge clk);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    sw    = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_simultaneous_and_reset();
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    test_toggle();
`endif
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/switch_debounce_bank.md
Name: switch_debounce_bank

Overview:
- Upstream conditioning stage between the Go Board push-switch pins and the combinational LED truth-table logic.
- For each of NUM_SW raw switch inputs, the block:
  - synchronises the input to i_Clk;
  - filters contact bounce with a per-channel stability counter;
  - presents clean levels plus one-cycle press/release pulses.
- The truth-table stage consumes o_Switch in place of the raw pins.

Parameters:
- NUM_SW, 4: number of independent switch channels.
- DEBOUNCE_LIMIT, 250000: consecutive cycles a new level must persist before it is accepted (10 ms at 25 MHz). Must be >= 2.
- SYNC_STAGES, 2: synchroniser flop depth. Must be >= 2.

Ports:
- i_Clk  in  1  system clock, 25 MHz.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Switch  in  NUM_SW  raw switch pins, asynchronous, 1 = pressed.
- o_Switch  out  NUM_SW  debounced switch levels.
- o_Press  out  NUM_SW  one-cycle pulse on an accepted 0->1 transition.
- o_Release  out  NUM_SW  one-cycle pulse on an accepted 1->0 transition.

Behaviour:
- Reset:
  - One clock, i_Clk. Reset is asynchronous and active-low (i_Rst_n); all flops clear immediately on assertion.
  - Reset values: sync chain 0, counters 0, o_Switch 0, o_Press 0, o_Release 0.
  - Deassertion is sampled on the next i_Clk rising edge.
- Synchroniser: i_Switch[k] passes through SYNC_STAGES flops; the last stage is sync[k].
- Per-channel counter:
  - Width $clog2(DEBOUNCE_LIMIT).
  - If sync[k] == o_Switch[k]: counter <= 0.
  - Else if counter == DEBOUNCE_LIMIT-1: o_Switch[k] <= sync[k] and counter <= 0.
  - Else: counter <= counter + 1.
- Acceptance timing: a level is accepted after exactly DEBOUNCE_LIMIT consecutive differing cycles. Pin-to-o_Switch latency is SYNC_STAGES + DEBOUNCE_LIMIT cycles for a clean edge.
- Bounce: any cycle where sync[k] matches o_Switch[k] clears the counter; no partial credit is kept. A glitch shorter than DEBOUNCE_LIMIT cycles never reaches o_Switch.
- Edge pulses:
  - o_Press[k] and o_Release[k] are registered.
  - They are high in the same cycle o_Switch[k] first shows the new value, and low on the following cycle.
  - They are never high together for the same channel.
- Counter range: the counter never exceeds DEBOUNCE_LIMIT-1, so no wrap-around is possible.
- Channel independence: channels do not share state. Simultaneous acceptance on several channels produces simultaneous pulses.
- Reset mid-count: the count is discarded and o_Switch returns to 0. A switch held pressed through reset is re-accepted DEBOUNCE_LIMIT cycles after sync fills, with an o_Press pulse.
- No combinational path from i_Switch to any output.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_TOGGLE_EN.
- When defined:
  - Adds output port o_Toggle, NUM_SW wide, reset value 0.
  - o_Toggle[k] inverts on the cycle after o_Press[k] is high, giving latched on/off LED control per switch.
- When undefined: the port and its flops are absent. All other behaviour is identical.

Decomposition:
- Shared package switch_pkg holds:
  - localparam CLK_HZ = 25_000_000;
  - localparam DEBOUNCE_MS = 10;
  - derived DEBOUNCE_LIMIT_DEFAULT;
  - NUM_SW_DEFAULT = 4.
- Sub-module debounce_channel is natural: one synchroniser, counter, level register and edge logic per bit.
- switch_debounce_bank is a generate loop over NUM_SW instances plus the optional toggle register.

Test Plan (DEBOUNCE_LIMIT=8, SYNC_STAGES=2):
- Reset: hold i_Rst_n=0 with i_Switch=4'hF -> o_Switch=0, o_Press=0, o_Release=0 throughout reset.
- Clean press: i_Switch[0] 0->1 and held -> o_Switch[0] rises exactly 10 cycles later; o_Press[0]=1 for that single cycle; other channels stay 0.
- Bounce rejection: i_Switch[1] toggles every 3 cycles for 40 cycles, then holds 1 -> o_Switch[1] stays 0 during bouncing and rises 10 cycles after the final stable edge; exactly one o_Press[1] pulse.
- Release and glitch: channel 2 accepted high; pulse i_Switch[2]=0 for 7 cycles -> no change. Then hold 0 for 8+ cycles -> o_Release[2] single pulse, o_Switch[2]=0.
- Simultaneous and reset: all four switches press on the same cycle -> o_Press=4'hF in one cycle. Assert i_Rst_n=0 at count 5 of a later release -> outputs clear asynchronously; after release, held-high channels re-press after 10 cycles.
- Toggle (SWITCH_DEBOUNCE_TOGGLE_EN defined): two accepted presses on channel 3 -> o_Toggle[3] goes 0->1->0, each change one cycle after its o_Press[3] pulse.
